// File: rtl/memoria_pkg.sv
// Shared main-memory types and constants, also imported by the cache controller.
package memoria_pkg;

  localparam int MEM_DATA_WIDTH = 3;
  localparam int MEM_ADDR_WIDTH = 4;
  localparam int MEM_DEPTH      = 16;

  typedef logic [MEM_DATA_WIDTH-1:0] mem_word_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] mem_addr_t;

  // Reset image used when the init-table build option is enabled.
  localparam mem_word_t MEM_INIT_TABLE [MEM_DEPTH] = '{
    3'b111, 3'b011, 3'b100, 3'b111, 3'b100, 3'b011, 3'b001, 3'b000,
    3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000, 3'b000
  };

endpackage

// File: rtl/memoria_principal_if.sv
// Cache-to-main-memory port bundle: word address, write data, write enable, read data.
interface memoria_principal_if;
  import memoria_pkg::*;

  // No valid/ready: every cycle is a transaction. The master drives address/data/wren
  // each cycle and samples q one clock later; it inserts its own wait cycle.
  mem_addr_t address;
  mem_word_t data;
  logic      wren;
  mem_word_t q;

  modport master (output address, output data, output wren, input q);
  modport slave  (input address, input data, input wren, output q);

endinterface

// File: rtl/memoria_principal.sv
// 16x3 single-port synchronous main memory with registered, write-through read data.
// Build option MEMORIA_PRINCIPAL_INIT_EN: reset loads MEM_INIT_TABLE instead of zeros.
module memoria_principal
  import memoria_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  memoria_principal_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;
  logic [ADDR_WIDTH-1:0] addr;

  assign addr  = bus.address;
  assign bus.q = q_q;

  // A write forwards its own data to q so the cache sees written-back words at once.
  always_comb begin
    mem_d = mem_q;
    q_d   = mem_q[addr];
    if (bus.wren) begin
      mem_d[addr] = bus.data;
      q_d         = bus.data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef MEMORIA_PRINCIPAL_INIT_EN
        mem_q[i] <= MEM_INIT_TABLE[i];
`else
        mem_q[i] <= '0;
`endif
      end
    end else begin
      q_q   <= q_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_memoria_principal.sv
// Bench for memoria_principal: vector table, hand-written corner sequences, random traffic vs array model.
module tb_memoria_principal;

  typedef struct {
    logic       rst;
    logic [3:0] addr;
    logic [2:0] data;
    logic       we;
    logic [2:0] exp_q;
  } vec_t;

  logic clock;
  logic reset;
  memoria_principal_if bus();

  memoria_principal dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [2:0] ref_mem  [16];
  logic [2:0] init_img [16];
  logic [2:0] ref_q;
  vec_t       vecs [16];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: one rising edge of an ideal 16-word memory.
  task automatic model_edge(input logic r, input logic [3:0] a, input logic [2:0] d, input logic w);
    if (r) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_img[i];
      ref_q = 3'b000;
    end else if (w) begin
      ref_mem[a] = d;
      ref_q      = d;
    end else begin
      ref_q = ref_mem[a];
    end
  endtask

  // driver: inputs are applied 1 time unit after an edge, outputs sampled 1 unit after the next
  task automatic step(input logic r, input logic [3:0] a, input logic [2:0] d, input logic w);
    reset       = r;
    bus.address = a;
    bus.data    = d;
    bus.wren    = w;
    @(posedge clock);
    model_edge(r, a, d, w);
    #1;
  endtask

  initial begin
    logic [2:0] prev_q;
`ifdef MEMORIA_PRINCIPAL_INIT_EN
    init_img = '{3'b111, 3'b011, 3'b100, 3'b111, 3'b100, 3'b011, 3'b001, 3'b000,
                 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000, 3'b000};
`else
    for (int i = 0; i < 16; i++) init_img[i] = 3'b000;
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = 3'bxxx;
    ref_q = 3'b000;

    reset       = 1'b1;
    bus.address = '0;
    bus.data    = '0;
    bus.wren    = 1'b0;

    // Reset then read every word.
    @(posedge clock); #1;
    step(1'b1, 4'd0, 3'b000, 1'b0);
    check("reset_q", bus.q, 3'b000);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), 3'b000, 1'b0);
      check($sformatf("reset_word_%0d", i), bus.q, init_img[i]);
    end
`ifdef MEMORIA_PRINCIPAL_INIT_EN
    step(1'b0, 4'd2, 3'b000, 1'b0);
    check("init_addr2", bus.q, 3'b100);
    step(1'b0, 4'd13, 3'b000, 1'b0);
    check("init_addr13", bus.q, 3'b111);
`endif

    // Vector table, expected values written out by hand.
    vecs[0]  = '{1'b1, 4'd1,  3'b111, 1'b1, 3'b000}; // reset beats write
    vecs[1]  = '{1'b0, 4'd5,  3'b110, 1'b1, 3'b110}; // write-through
    vecs[2]  = '{1'b0, 4'd5,  3'b000, 1'b0, 3'b110};
    vecs[3]  = '{1'b0, 4'd9,  3'b101, 1'b1, 3'b101};
    vecs[4]  = '{1'b0, 4'd3,  3'b010, 1'b1, 3'b010};
    vecs[5]  = '{1'b0, 4'd7,  3'b100, 1'b1, 3'b100};
    vecs[6]  = '{1'b0, 4'd3,  3'b000, 1'b0, 3'b010};
    vecs[7]  = '{1'b0, 4'd7,  3'b000, 1'b0, 3'b100};
    vecs[8]  = '{1'b0, 4'd3,  3'b000, 1'b0, 3'b010};
    vecs[9]  = '{1'b0, 4'd12, 3'b011, 1'b1, 3'b011}; // write-back
    vecs[10] = '{1'b0, 4'd12, 3'b000, 1'b0, 3'b011};
    vecs[11] = '{1'b0, 4'd12, 3'b001, 1'b1, 3'b001};
    vecs[12] = '{1'b0, 4'd12, 3'b110, 1'b1, 3'b110}; // last write wins
    vecs[13] = '{1'b0, 4'd12, 3'b000, 1'b0, 3'b110};
    vecs[14] = '{1'b0, 4'd9,  3'b000, 1'b0, 3'b101};
    vecs[15] = '{1'b0, 4'd5,  3'b000, 1'b0, 3'b110};
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].we);
      check($sformatf("vec_%0d", i), bus.q, vecs[i].exp_q);
    end

    // Reset-vs-write left word 1 at its reset value; neighbours of 5 untouched.
    step(1'b0, 4'd1, 3'b000, 1'b0);
    check("reset_drops_write", bus.q, init_img[1]);
    step(1'b0, 4'd4, 3'b000, 1'b0);
    check("neigh_4", bus.q, init_img[4]);
    step(1'b0, 4'd6, 3'b000, 1'b0);
    check("neigh_6", bus.q, init_img[6]);

    // Latency: q must not move until the edge after the address changes.
    step(1'b0, 4'd3, 3'b000, 1'b0);
    check("lat_a3", bus.q, 3'b010);
    bus.address = 4'd7;
    #2;
    check("lat_hold", bus.q, 3'b010);
    @(posedge clock); model_edge(1'b0, 4'd7, 3'b000, 1'b0); #1;
    check("lat_a7", bus.q, 3'b100);
    bus.address = 4'd3;
    #2;
    check("lat_hold2", bus.q, 3'b100);
    @(posedge clock); model_edge(1'b0, 4'd3, 3'b000, 1'b0); #1;
    check("lat_a3b", bus.q, 3'b010);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      check("random", bus.q, ref_q);
    end

    // Final sweep of the whole array.
    for (int i = 0; i < 16; i++) begin
      prev_q = ref_mem[i];
      step(1'b0, 4'(i), 3'b000, 1'b0);
      check($sformatf("final_word_%0d", i), bus.q, prev_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
